// File: rtl/maxnet_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : maxnet_feeder_if
//  Description : Sample stream and result stream bundle between the Maxnet
//                feeder and its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface maxnet_feeder_if #(
  parameter int DW = 5
);
  // sample stream, environment -> feeder
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  // result stream, feeder -> environment
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          res_err;

  // environment side: produces samples, consumes results
  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_data, res_valid, res_err
  );

  // feeder side: consumes samples, produces results
  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_data, res_valid, res_err
  );
endinterface
`default_nettype wire

// File: rtl/maxnet_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : maxnet_feeder
//  Description : Streaming front end for the Maxnet competition core. Gathers
//                four samples plus the two inhibition weights, pulses start,
//                waits for the rising edge of done and presents max on a
//                valid/ready result port.
//                Optional watchdog: define MAXNET_FEEDER_TIMEOUT_EN to abort
//                a WAIT that lasts TIMEOUT cycles (result 0, res_err = 1).
//  Revision    : 1.0  initial release
// ============================================================================
module maxnet_feeder #(
  parameter int DW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  maxnet_feeder_if.slave bus,
  input  logic [DW-1:0] w1_cfg,
  input  logic [DW-1:0] w2_cfg,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic          start,
  input  logic          done,
  input  logic [DW-1:0] max,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("maxnet_feeder: TIMEOUT must be in 1..255");
  end

  state_t        r_state;
  logic [1:0]    r_count;
  logic          r_done_q;
  logic [DW-1:0] r_res_data;
  logic          r_res_valid;
  logic          w_beat;
  logic          w_complete;

`ifdef MAXNET_FEEDER_TIMEOUT_EN
  localparam logic [7:0] c_timeout_m1 = 8'(TIMEOUT - 1);
  logic [7:0]    r_wdog;
  logic          r_res_err;
  assign bus.res_err = r_res_err;
`else
  assign bus.res_err = 1'b0;
`endif

  // Handshake strobes; in_ready and busy decode the state only.
  assign bus.in_ready  = (r_state == S_COLLECT);
  assign busy          = (r_state != S_COLLECT);
  assign w_beat        = bus.in_valid && (r_state == S_COLLECT);
  // A done that is already high on WAIT entry shows done_q = 1, so only a
  // fresh rise seen while waiting counts as completion.
  assign w_complete    = (r_state == S_WAIT) && done && !r_done_q;
  assign bus.res_data  = r_res_data;
  assign bus.res_valid = r_res_valid;

  // One-cycle history of done for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done_q <= 1'b0;
    else      r_done_q <= done;
  end

  // Control FSM with the sample, weight and result registers it loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_COLLECT;
      r_count     <= 2'd0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      x4          <= '0;
      w1          <= '0;
      w2          <= '0;
      start       <= 1'b0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
`ifdef MAXNET_FEEDER_TIMEOUT_EN
      r_wdog      <= 8'd0;
      r_res_err   <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_beat) begin
            case (r_count)
              2'd0: begin
                x1 <= bus.in_data;
                w1 <= w1_cfg;
                w2 <= w2_cfg;
              end
              2'd1:    x2 <= bus.in_data;
              2'd2:    x3 <= bus.in_data;
              default: x4 <= bus.in_data;
            endcase
            r_count <= r_count + 2'd1;
            if (r_count == 2'd3) begin
              r_state <= S_LAUNCH;
              start   <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
`ifdef MAXNET_FEEDER_TIMEOUT_EN
          r_wdog  <= 8'd0;
`endif
        end
        S_WAIT: begin
          if (w_complete) begin
            r_res_data  <= max;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
`ifdef MAXNET_FEEDER_TIMEOUT_EN
            r_res_err   <= 1'b0;
          end else if (r_wdog == c_timeout_m1) begin
            r_res_data  <= '0;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_wdog      <= r_wdog + 8'd1;
`endif
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule
`default_nettype wire
